// File: rtl/mux2_arbiter.sv
// Two-source round-robin arbiter feeding a single registered output slot.
// The sel output tells the downstream 2:1 mux which source the held word came from.
module mux2_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
);

    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_data_q,  y_data_d;
    logic             sel_q,     sel_d;
    logic             last_sel_q, last_sel_d;
    logic [7:0]       cnt_a_q,   cnt_a_d;
    logic [7:0]       cnt_b_q,   cnt_b_d;

    logic acc;
    logic grant_a;
    logic grant_b;

    always_comb begin
        acc     = !y_valid_q || y_ready;
        // On a tie the source opposite to the previous winner is granted.
        grant_a = acc && a_valid && (!b_valid || last_sel_q);
        grant_b = acc && b_valid && (!a_valid || !last_sel_q);

        a_ready = grant_a && !rst;
        b_ready = grant_b && !rst;

        y_valid_d  = y_valid_q;
        y_data_d   = y_data_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;

        if (grant_a || grant_b) begin
            y_valid_d  = 1'b1;
            y_data_d   = grant_b ? b_data : a_data;
            sel_d      = grant_b;
            last_sel_d = grant_b;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end

        if (grant_a) begin
            cnt_a_d = cnt_a_q + 8'd1;
        end
        if (grant_b) begin
            cnt_b_d = cnt_b_q + 8'd1;
        end
    end

    // last_sel resets to B so that A wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
            cnt_a_q    <= 8'd0;
            cnt_b_q    <= 8'd0;
        end else begin
            y_valid_q  <= y_valid_d;
            y_data_q   <= y_data_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign sel     = sel_q;
    assign cnt_a   = cnt_a_q;
    assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed vector table plus hand-written reset/wrap sequences and a random
// scoreboard run for mux2_arbiter.
module tb_mux2_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] y_data;
    logic       y_valid;
    logic       y_ready;
    logic       sel;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    mux2_arbiter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .sel     (sel),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       yr;
        logic       e_ardy;
        logic       e_brdy;
        logic       e_yv;
        logic [7:0] e_yd;
        logic       e_sel;
        logic [7:0] e_ca;
        logic [7:0] e_cb;
    } vec_t;

    vec_t vecs[20];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        a_valid = v.av;
        a_data  = v.ad;
        b_valid = v.bv;
        b_data  = v.bd;
        y_ready = v.yr;
        #1;
        checkOutput($sformatf("vec%0d a_ready", idx), {7'd0, a_ready}, {7'd0, v.e_ardy});
        checkOutput($sformatf("vec%0d b_ready", idx), {7'd0, b_ready}, {7'd0, v.e_brdy});
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d y_valid", idx), {7'd0, y_valid}, {7'd0, v.e_yv});
        checkOutput($sformatf("vec%0d y_data", idx), y_data, v.e_yd);
        checkOutput($sformatf("vec%0d sel", idx), {7'd0, sel}, {7'd0, v.e_sel});
        checkOutput($sformatf("vec%0d cnt_a", idx), cnt_a, v.e_ca);
        checkOutput($sformatf("vec%0d cnt_b", idx), cnt_b, v.e_cb);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] item;
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    int         fires_a;
    int         fires_b;

    task automatic sampleScoreboard();
        tests_run++;
        if (a_ready && b_ready) begin
            tests_failed++;
            $display("[TB] FAIL ready_excl: got a_ready=1 b_ready=1 expected at most one");
        end
        if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL sb_dup: got word %0h with nothing pending", y_data);
            end else begin
                item = exp_q.pop_front();
                checkOutput("sb_data", y_data, item[7:0]);
                checkOutput("sb_sel", {7'd0, sel}, {7'd0, item[8]});
            end
        end
        if (a_valid && a_ready) begin
            exp_q.push_back({1'b0, a_data});
            seq_a++;
            fires_a++;
        end
        if (b_valid && b_ready) begin
            exp_q.push_back({1'b1, b_data});
            seq_b++;
            fires_b++;
        end
    endtask

    initial begin
        // Table: inputs | exp a_ready b_ready | exp y_valid y_data sel cnt_a cnt_b (after edge)
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 8'd0};
        vecs[1]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'd1, 8'd1};
        vecs[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd2, 8'd1};
        vecs[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'd2, 8'd2};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 8'd2, 8'd2};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 8'd2, 8'd3};
        vecs[12] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'd3, 8'd3};
        vecs[13] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'd3, 8'd3};
        vecs[14] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'd3, 8'd3};
        vecs[15] = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'd3, 8'd3};
        vecs[16] = '{1'b1, 8'h77, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'd3, 8'd4};
        vecs[17] = '{1'b1, 8'h77, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 8'd4, 8'd4};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'd4, 8'd4};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 8'd4, 8'd4};

        // Reset is asserted before any clock edge; outputs must already be cleared.
        rst     = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'hEE;
        b_valid = 1'b1;
        b_data  = 8'hDD;
        y_ready = 1'b1;
        #1;
        checkOutput("rst y_valid", {7'd0, y_valid}, 8'd0);
        checkOutput("rst y_data", y_data, 8'd0);
        checkOutput("rst sel", {7'd0, sel}, 8'd0);
        checkOutput("rst cnt_a", cnt_a, 8'd0);
        checkOutput("rst cnt_b", cnt_b, 8'd0);
        checkOutput("rst a_ready", {7'd0, a_ready}, 8'd0);
        checkOutput("rst b_ready", {7'd0, b_ready}, 8'd0);
        doReset();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset between edges while a word is held.
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'hC3;
        b_valid = 1'b0;
        y_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("async pre y_valid", {7'd0, y_valid}, 8'd1);
        checkOutput("async pre y_data", y_data, 8'hC3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async y_valid", {7'd0, y_valid}, 8'd0);
        checkOutput("async y_data", y_data, 8'd0);
        checkOutput("async sel", {7'd0, sel}, 8'd0);
        checkOutput("async cnt_a", cnt_a, 8'd0);
        checkOutput("async cnt_b", cnt_b, 8'd0);
        checkOutput("async a_ready", {7'd0, a_ready}, 8'd0);
        @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'hA1;
        b_valid = 1'b1;
        b_data  = 8'hB2;
        y_ready = 1'b1;
        #1;
        checkOutput("post-rst a_ready", {7'd0, a_ready}, 8'd1);
        checkOutput("post-rst b_ready", {7'd0, b_ready}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("post-rst y_data", y_data, 8'hA1);
        checkOutput("post-rst sel", {7'd0, sel}, 8'd0);
        checkOutput("post-rst cnt_a", cnt_a, 8'd1);

        // 256 back-to-back A-only transfers wrap cnt_a to zero.
        doReset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_data  = 8'(i);
            b_valid = 1'b0;
            y_ready = 1'b1;
            @(posedge clk);
            #1;
            if (i == 254) begin
                checkOutput("wrap cnt_a 255", cnt_a, 8'hFF);
            end
        end
        checkOutput("wrap cnt_a", cnt_a, 8'h00);
        checkOutput("wrap cnt_b", cnt_b, 8'h00);
        checkOutput("wrap y_data", y_data, 8'hFF);
        checkOutput("wrap y_valid", {7'd0, y_valid}, 8'd1);

        // Random valid/ready traffic against an in-order scoreboard.
        doReset();
        seq_a   = 8'd0;
        seq_b   = 8'd0;
        fires_a = 0;
        fires_b = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_data  = {1'b0, seq_a[6:0]};
            b_data  = {1'b1, seq_b[6:0]};
            y_ready = ($urandom_range(0, 3) != 0);
            #1;
            sampleScoreboard();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_valid = 1'b0;
            b_valid = 1'b0;
            y_ready = 1'b1;
            #1;
            sampleScoreboard();
        end
        checkOutput("sb drained", 8'(exp_q.size()), 8'd0);
        checkOutput("sb cnt_a", cnt_a, 8'(fires_a));
        checkOutput("sb cnt_b", cnt_b, 8'(fires_b));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data path width of each stream SHALL be WIDTH bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_data  input  WIDTH  source A payload.
REQ-005 a_valid  input  1  source A offers a_data.
REQ-006 a_ready  output  1  block accepts source A this cycle.
REQ-007 b_data  input  WIDTH  source B payload.
REQ-008 b_valid  input  1  source B offers b_data.
REQ-009 b_ready  output  1  block accepts source B this cycle.
REQ-010 y_data  output  WIDTH  registered output payload.
REQ-011 y_valid  output  1  y_data holds an unconsumed word.
REQ-012 y_ready  input  1  downstream consumes y_data this cycle.
REQ-013 sel  output  1  source of the word in y_data: 0 = A, 1 = B; this is the select line for the downstream 2:1 mux.
REQ-014 cnt_a  output  8  count of words accepted from A.
REQ-015 cnt_b  output  8  count of words accepted from B.

Function
REQ-016 A transfer on any port SHALL occur only in a cycle where both valid and ready are high at the rising edge.
REQ-017 The output register SHALL be one entry; accept condition acc = !y_valid || y_ready.
REQ-018 a_ready and b_ready SHALL be combinational, and at most one SHALL be high in any cycle.
REQ-019 Arbitration when acc=1: only A valid -> grant A; only B valid -> grant B; both valid -> grant the source opposite to last_sel; neither valid -> no grant.
REQ-020 last_sel SHALL be an internal register, updated to the granted source on every accepted transfer, and unchanged otherwise.
REQ-021 The granted source's ready SHALL equal acc; the other source's ready SHALL be 0.
REQ-022 On grant, y_data SHALL load the granted payload, sel SHALL load the granted source, and y_valid SHALL be 1 at the next edge (latency 1 cycle).
REQ-023 If y_valid && y_ready and no grant occurs, y_valid SHALL drop to 0 at the next edge; y_data and sel SHALL keep their values.
REQ-024 While y_valid && !y_ready, y_data, sel and y_valid SHALL remain stable, and a_ready = b_ready = 0.
REQ-025 Simultaneous consume and grant (y_valid && y_ready && grant) SHALL sustain one word per cycle with no bubble.
REQ-026 cnt_a / cnt_b SHALL increment by 1 on each accepted A / B transfer, wrapping 255 -> 0 with no flag.
REQ-027 The block SHALL never drop or duplicate a word; order per source SHALL be preserved.

Reset
REQ-028 While rst=1, regardless of clk: y_valid=0, y_data=0, sel=0, cnt_a=0, cnt_b=0, last_sel=1 (A wins first tie).
REQ-029 While rst=1, a_ready=b_ready=0.
REQ-030 Reset asserted mid-transfer SHALL discard the held word; the first grant after deassertion SHALL follow REQ-019 from the reset values.

Verification
REQ-031 Reset then a_valid=b_valid=1 (a_data=0x11, b_data=0x22), y_ready=1 for 4 cycles -> outputs 0x11/sel=0, 0x22/sel=1, 0x11/sel=0, 0x22/sel=1 on consecutive cycles; cnt_a=2, cnt_b=2.
REQ-032 Only b_valid=1 with b_data=0x5A, y_ready=0 -> one edge later y_valid=1, y_data=0x5A, sel=1; b_ready=0 while stalled; y_data stays 0x5A for 5 stall cycles, then 1 cycle with y_ready=1 -> consumed and cnt_b=1.
REQ-033 Stall with y_valid=1, a_valid=1 changing a_data each cycle -> a_ready=0 throughout, y_data unchanged, cnt_a unchanged.
REQ-034 256 back-to-back A-only transfers -> cnt_a wraps to 0x00, cnt_b=0.
REQ-035 Assert rst asynchronously (between edges) while y_valid=1 -> y_valid, sel, y_data, cnt_a and cnt_b go to 0 immediately; after release with both valid, first grant goes to A.
REQ-036 Random valid/ready stimulus for 10k cycles against a scoreboard -> no loss, duplication or reorder per source; no cycle with a_ready=b_ready=1.
